iter_alu: RTL

- Parametrised successor to the team's fixed 4-bit registered ALU.
- Operand width is set by WIDTH, and operands and results move over valid/ready handshakes.
- Add, subtract, logic and NOT complete in a single cycle. Multiply and divide run iteratively, one bit per cycle, and divide returns both quotient and remainder.
- Sits between the input-capture stage and the output register in the top-level wrapper.

---
 rtl/alu_pkg.sv | 19 +
 rtl/iter_muldiv_unit.sv | 75 +++++++
 rtl/iter_alu.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the iterative ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/iter_muldiv_unit.sv
// Bit-serial multiplier / restoring divider. One step per clock after start.
// acc holds {high, low}: for multiply {partial product, multiplier};
// for divide {remainder, quotient-being-formed}. result is the value acc takes
// on the current edge, so done and result can be captured together.
module iter_muldiv_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic               running;
  logic               div_mode;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  // Next accumulator value for one shift-add or one restoring shift-subtract.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_next  = acc;
    if (div_mode) begin
      if (!div_diff[WIDTH])
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  assign done   = running && (counter == LAST);
  assign result = acc_next;

  // Load operands on start, then iterate exactly WIDTH times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running  <= 1'b0;
      div_mode <= 1'b0;
      counter  <= '0;
      opnd     <= '0;
      acc      <= '0;
    end else if (start) begin
      running  <= 1'b1;
      div_mode <= is_div;
      counter  <= '0;
      opnd     <= is_div ? b : a;
      acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
    end else if (running) begin
      acc <= acc_next;
      if (counter == LAST) begin
        running <= 1'b0;
        counter <= '0;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/not, iterative mul/div.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_zero,
  output logic               out_dz,
  output logic               busy
);

  state_t             state;
  logic               accept;
  logic               iterative;
  logic               pending_dz;
  logic               unit_done;
  logic [2*WIDTH-1:0] unit_result;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] single_res;

  // Ready in IDLE, or in DONE when the current result is being taken this edge.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign iterative = (in_op == OP_MUL) || (in_op == OP_DIV);
  assign a_ext     = {{WIDTH{1'b0}}, in_a};
  assign b_ext     = {{WIDTH{1'b0}}, in_b};

  // Single-cycle datapath, fully decoded so no opcode yields X.
  always_comb begin
    single_res = '0;
    case (in_op)
      OP_ADD:  single_res = a_ext + b_ext;
      OP_SUB:  single_res = a_ext - b_ext;
      OP_AND:  single_res = a_ext & b_ext;
      OP_OR:   single_res = a_ext | b_ext;
      OP_XOR:  single_res = a_ext ^ b_ext;
      OP_NOT:  single_res = {~in_b, ~in_a};
      default: single_res = '0;
    endcase
  end

  iter_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && iterative),
    .is_div (in_op == OP_DIV),
    .a      (in_a),
    .b      (in_b),
    .done   (unit_done),
    .result (unit_result)
  );

  // Control FSM and output registers; a reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_dz     <= 1'b0;
      busy       <= 1'b0;
      pending_dz <= 1'b0;
    end else if (accept) begin
      if (iterative) begin
        state      <= BUSY;
        busy       <= 1'b1;
        out_valid  <= 1'b0;
        pending_dz <= (in_op == OP_DIV) && (in_b == '0);
      end else begin
        state      <= DONE;
        out_valid  <= 1'b1;
        out_result <= single_res;
        out_zero   <= (single_res == '0);
        out_dz     <= 1'b0;
      end
    end else begin
      case (state)
        BUSY: begin
          if (unit_done) begin
            state      <= DONE;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            out_result <= pending_dz ? '0 : unit_result;
            out_zero   <= pending_dz || (unit_result == '0);
            out_dz     <= pending_dz;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
